// File: rtl/dm_ctrl.sv
// Data-memory controller: turns a core load/store into a ready-handshaked RAM word
// access with byte-lane steering, load extension, stall, misalign and timeout reporting.
module dm_ctrl #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_write,
  input  logic [2:0]        dm_op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              resp_valid,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ready
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] OP_WORD = 3'b000;
  localparam logic [2:0] OP_HS   = 3'b001;
  localparam logic [2:0] OP_HU   = 3'b010;
  localparam logic [2:0] OP_BS   = 3'b011;
  localparam logic [2:0] OP_BU   = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [31:0]        rdata_q, rdata_d;
  logic               bus_err_q, bus_err_d;
  logic [2:0]         op_q, op_d;
  logic [1:0]         lo_q, lo_d;
  logic [3:0]         we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               aligned_c;
  logic               accept_c;
  logic               timeout_c;
  logic [3:0]         we_c;
  logic [31:0]        wlane_c;
  logic [31:0]        shifted_c;
  logic [31:0]        load_c;
  logic               unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];

  // Request legality and lane preparation from the raw core signals
  always_comb begin
    aligned_c = 1'b0;
    we_c      = 4'b0000;
    wlane_c   = wdata;
    case (dm_op)
      OP_WORD: begin
        aligned_c = (addr[1:0] == 2'b00);
        we_c      = 4'b1111;
      end
      OP_HS, OP_HU: begin
        aligned_c = ~addr[0];
        we_c      = addr[1] ? 4'b1100 : 4'b0011;
        wlane_c   = {2{wdata[15:0]}};
      end
      OP_BS, OP_BU: begin
        aligned_c = 1'b1;
        we_c      = 4'b0001 << addr[1:0];
        wlane_c   = {4{wdata[7:0]}};
      end
      default: aligned_c = 1'b0;
    endcase
    if (!mem_write) we_c = 4'b0000;
  end

  assign accept_c  = (state_q == S_IDLE) && req_valid && aligned_c;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign timeout_c = (cnt_inc == CNT_W'(TIMEOUT_CYC));

  // Load lane selection and extension from the latched request
  always_comb begin
    shifted_c = ram_rdata >> {lo_q, 3'b000};
    case (op_q)
      OP_HS:   load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      OP_HU:   load_c = {16'h0000, shifted_c[15:0]};
      OP_BS:   load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      OP_BU:   load_c = {24'h000000, shifted_c[7:0]};
      default: load_c = ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      op_q      <= '0;
      lo_q      <= '0;
      we_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      op_q      <= op_d;
      lo_q      <= lo_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept_c) state_d = S_ACCESS;
      S_ACCESS: begin
        if (ram_ready)      state_d = S_DONE;
        else if (timeout_c) state_d = S_IDLE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request latch, wait counter and response capture
  always_comb begin
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    op_d      = op_q;
    lo_d      = lo_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (accept_c) begin
      cnt_d   = '0;
      op_d    = dm_op;
      lo_d    = addr[1:0];
      we_d    = we_c;
      addr_d  = addr[ADDR_W+1:2];
      wdata_d = wlane_c;
    end else if (state_q == S_ACCESS) begin
      cnt_d = cnt_inc;
      if (ram_ready) begin
        rdata_d = (we_q != 4'b0000) ? 32'h0 : load_c;
      end else if (timeout_c) begin
        rdata_d   = 32'h0;
        bus_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    stall      = accept_c || (state_q == S_ACCESS);
    misalign   = (state_q == S_IDLE) && req_valid && !aligned_c;
    ram_en     = (state_q == S_ACCESS);
    ram_we     = (state_q == S_ACCESS) ? we_q : 4'b0000;
    resp_valid = (state_q == S_DONE);
  end

  assign rdata     = rdata_q;
  assign bus_err   = bus_err_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: directed cases plus random loads/stores checked against an
// arithmetic model of lane selection, byte enables and extension.
module tb_dm_ctrl;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              mem_write;
  logic [2:0]        dm_op;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              resp_valid;
  logic              stall;
  logic              misalign;
  logic              bus_err;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_ready;

  int n_cmp = 0;
  int n_err = 0;

  dm_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_write(mem_write),
    .dm_op(dm_op), .addr(addr), .wdata(wdata), .rdata(rdata),
    .resp_valid(resp_valid), .stall(stall), .misalign(misalign),
    .bus_err(bus_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 for illegal op codes
  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_ok(input logic [2:0] op, input logic [31:0] a);
    int sz = op_size(op);
    if (sz == 0) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [3:0] model_we(input bit wr, input logic [2:0] op, input logic [31:0] a);
    int sz = op_size(op);
    if (!wr) return 4'b0000;
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
    longint unsigned v = longint'(wd);
    case (op_size(op))
      2:       return 32'((v & 64'hFFFF) * 64'h0001_0001);
      1:       return 32'((v & 64'hFF) * 64'h0101_0101);
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_rdata(input bit wr, input logic [2:0] op,
                                              input logic [31:0] a, input logic [31:0] rw);
    int sz = op_size(op);
    longint unsigned span, v;
    if (wr) return 32'h0;
    span = 64'd1 << (8 * sz);
    v = (longint'(rw) >> (8 * (a % 4))) % span;
    if ((op == 3'd1 || op == 3'd3) && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    return 32'(v);
  endfunction

  // One full request from its IDLE cycle; waits >= TIMEOUT means RAM never answers
  task automatic run_txn(input bit wr, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rw, input int waits);
    logic [3:0]  e_we   = model_we(wr, op, a);
    logic [31:0] e_wd   = model_wdata(op, wd);
    logic [31:0] e_rd   = model_rdata(wr, op, a, rw);
    logic [31:0] e_addr = 32'((a / 4) % (1 << ADDR_W));
    int n_acc = (waits >= int'(TIMEOUT)) ? int'(TIMEOUT) : waits + 1;

    @(negedge clk);
    req_valid = 1'b1; mem_write = wr; dm_op = op; addr = a; wdata = wd;
    ram_ready = 1'($urandom_range(0, 1)); ram_rdata = $urandom;
    #1;
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);
    chk("idle_bus_err", 32'(bus_err), 32'd0);
    chk("idle_ram_en", 32'(ram_en), 32'd0);
    if (!model_ok(op, a)) begin
      chk("misalign_pulse", 32'(misalign), 32'd1);
      chk("misalign_stall", 32'(stall), 32'd0);
      @(negedge clk);
      req_valid = 1'b0; ram_ready = 1'b0;
      #1;
      chk("misalign_no_ram_en", 32'(ram_en), 32'd0);
      chk("misalign_no_resp", 32'(resp_valid), 32'd0);
      chk("misalign_clear", 32'(misalign), 32'd0);
      return;
    end
    chk("idle_stall", 32'(stall), 32'd1);
    chk("idle_misalign", 32'(misalign), 32'd0);

    for (int i = 0; i < n_acc; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
      dm_op = 3'($urandom_range(0, 7)); mem_write = 1'($urandom_range(0, 1));
      ram_ready = (i == waits); ram_rdata = (i == waits) ? rw : $urandom;
      #1;
      chk("acc_ram_en", 32'(ram_en), 32'd1);
      chk("acc_stall", 32'(stall), 32'd1);
      chk("acc_ram_we", 32'(ram_we), 32'(e_we));
      chk("acc_ram_addr", 32'(ram_addr), e_addr);
      if (wr) chk("acc_ram_wdata", ram_wdata, e_wd);
      chk("acc_misalign", 32'(misalign), 32'd0);
      chk("acc_resp_valid", 32'(resp_valid), 32'd0);
    end

    @(negedge clk);
    req_valid = 1'b0; ram_ready = 1'($urandom_range(0, 1)); ram_rdata = $urandom;
    #1;
    if (waits >= int'(TIMEOUT)) begin
      chk("to_bus_err", 32'(bus_err), 32'd1);
      chk("to_stall", 32'(stall), 32'd0);
      chk("to_ram_en", 32'(ram_en), 32'd0);
      chk("to_resp_valid", 32'(resp_valid), 32'd0);
      chk("to_rdata", rdata, 32'h0);
    end else begin
      chk("done_resp_valid", 32'(resp_valid), 32'd1);
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_ram_en", 32'(ram_en), 32'd0);
      chk("done_rdata", rdata, e_rd);
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; mem_write = 1'b0; dm_op = 3'd0;
    addr = 32'h0; wdata = 32'h0; ram_rdata = 32'h0; ram_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases
    run_txn(1'b0, 3'd0, 32'h10, 32'h0, 32'h8765_4321, 0);
    run_txn(1'b1, 3'd4, 32'h23, 32'h0000_00AB, 32'h0, 0);
    run_txn(1'b0, 3'd3, 32'h06, 32'h0, 32'h0080_0000, 0);
    run_txn(1'b0, 3'd4, 32'h06, 32'h0, 32'h0080_0000, 0);
    run_txn(1'b0, 3'd1, 32'h03, 32'h0, 32'h0, 0);
    run_txn(1'b1, 3'd0, 32'h40, 32'hDEAD_BEEF, 32'h0, 3);
    run_txn(1'b0, 3'd1, 32'h0E, 32'h0, 32'h8001_7FFF, 1);
    run_txn(1'b1, 3'd2, 32'h0A, 32'h1234_5678, 32'h0, 0);
    run_txn(1'b0, 3'd6, 32'h00, 32'h0, 32'h0, 0);
    run_txn(1'b0, 3'd0, 32'h80, 32'h0, 32'h0, int'(TIMEOUT));
    run_txn(1'b0, 3'd0, 32'h84, 32'h0, 32'hCAFE_F00D, 0);

    // Reset in the middle of an access
    @(negedge clk);
    req_valid = 1'b1; mem_write = 1'b0; dm_op = 3'd0; addr = 32'h20; ram_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("pre_rst_ram_en", 32'(ram_en), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ram_en", 32'(ram_en), 32'd0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      logic [2:0]  op = 3'($urandom_range(0, 5));
      logic [31:0] a  = $urandom;
      int w = ($urandom_range(0, 15) == 0) ? int'(TIMEOUT) : int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a & ~((op == 3'd0) ? 32'h3 : 32'h1);
      run_txn(1'($urandom_range(0, 1)), op, a, $urandom, $urandom, w);
    end

    @(negedge clk);
    #1;
    chk("end_bus_err", 32'(bus_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
